// File: rtl/dtmf_tone_detector.sv
// dtmf_tone_detector
// Measures the period of an incoming square-wave tone against the 1 MHz
// system clock, classifies it against the eight DTMF frequencies and
// reports a stable tone code once CONFIRM consecutive periods agree.
`timescale 1ns/1ps

module dtmf_tone_detector #(
   parameter int CONFIRM = 4
) (
   input  logic        clk_1m_in,
   input  logic        reset_b,
   input  logic        tone_in,
   output logic        tone_valid,
   output logic [2:0]  tone_code,
   output logic [10:0] period_out,
   output logic        period_strobe
);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam logic [10:0] COUNT_MAX = 11'd2047;
   localparam logic [3:0]  CONFIRM_W = 4'(CONFIRM);

   // Inclusive period windows in clock cycles, indexed by tone code.
   localparam logic [10:0] WIN_LO [8] = '{11'd1414, 11'd1280, 11'd1156, 11'd1047,
                                          11'd815,  11'd738,  11'd667,  11'd603};
   localparam logic [10:0] WIN_HI [8] = '{11'd1456, 11'd1318, 11'd1192, 11'd1079,
                                          11'd839,  11'd760,  11'd687,  11'd621};

   state_t      state_reg, state_next;
   logic        sync1_reg, sync2_reg, sync3_reg;
   logic        rise_reg;
   logic [10:0] count_reg, count_next;
   logic [10:0] period_reg, period_next;
   logic        strobe_reg, strobe_next;
   logic        timeout;

   logic [7:0]  hit_vec;
   logic        hit;
   logic [2:0]  cls;

   logic [3:0]  match_reg, match_next;
   logic [2:0]  cand_reg, cand_next;
   logic        valid_reg, valid_next;
   logic [2:0]  code_reg, code_next;

   // Two-flop synchronizer, a third flop for edge detection, and a
   // registered rising-edge flag that the FSM consumes.
   always_ff @(posedge clk_1m_in or negedge reset_b) begin
      if (!reset_b) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         sync3_reg <= 1'b0;
         rise_reg  <= 1'b0;
      end else begin
         sync1_reg <= tone_in;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
         rise_reg  <= sync2_reg & ~sync3_reg;
      end
   end

   // FSM and period counter state registers.
   always_ff @(posedge clk_1m_in or negedge reset_b) begin
      if (!reset_b) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         period_reg <= '0;
         strobe_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         period_reg <= period_next;
         strobe_reg <= strobe_next;
      end
   end

   // Next-state logic: an edge in MEASURE captures the period even when the
   // counter has just saturated, so the edge takes priority over timeout.
   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      period_next = period_reg;
      strobe_next = 1'b0;
      timeout     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rise_reg) begin
               count_next = 11'd1;
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (rise_reg) begin
               period_next = count_reg;
               strobe_next = 1'b1;
               count_next  = 11'd1;
            end else if (count_reg == COUNT_MAX) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end else begin
               count_next = count_reg + 11'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One comparator pair per DTMF window on the captured period.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_window
         assign hit_vec[gi] = (period_reg >= WIN_LO[gi]) && (period_reg <= WIN_HI[gi]);
      end
   endgenerate

   // Windows are disjoint, so at most one bit of hit_vec is set.
   always_comb begin
      hit = 1'b0;
      cls = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (hit_vec[i]) begin
            hit = 1'b1;
            cls = 3'(i);
         end
      end
   end

   // Confirmation: count consecutive same-class periods; a miss, a class
   // change or a timeout drops tone_valid while tone_code keeps its value.
   always_comb begin
      match_next = match_reg;
      cand_next  = cand_reg;
      valid_next = valid_reg;
      code_next  = code_reg;
      if (strobe_reg) begin
         if (!hit) begin
            match_next = 4'd0;
            valid_next = 1'b0;
         end else if (cls == cand_reg) begin
            match_next = (match_reg >= CONFIRM_W) ? CONFIRM_W : 4'(match_reg + 4'd1);
         end else begin
            cand_next  = cls;
            match_next = 4'd1;
            valid_next = 1'b0;
         end
         if (hit && (match_next == CONFIRM_W)) begin
            valid_next = 1'b1;
            code_next  = cand_next;
         end
      end else if (timeout) begin
         match_next = 4'd0;
         valid_next = 1'b0;
      end
   end

   // Confirmation state registers.
   always_ff @(posedge clk_1m_in or negedge reset_b) begin
      if (!reset_b) begin
         match_reg <= '0;
         cand_reg  <= '0;
         valid_reg <= 1'b0;
         code_reg  <= '0;
      end else begin
         match_reg <= match_next;
         cand_reg  <= cand_next;
         valid_reg <= valid_next;
         code_reg  <= code_next;
      end
   end

   assign tone_valid    = valid_reg;
   assign tone_code     = code_reg;
   assign period_out    = period_reg;
   assign period_strobe = strobe_reg;

endmodule
